// File: rtl/ddr_ref_pkg.sv
// Shared DDR refresh types and defaults for the refresh controller and the issue tracker.
// The postpone limit defaults here are shared with the refresh controller.
package ddr_ref_pkg;

    // IDLE: nothing owed | REQ: refresh presented | GAP: post-ack spacing
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } ref_trk_state_t;

    localparam int REF_CNT_W         = 4;
    localparam int DEF_MAX_PENDING   = 8;
    localparam int DEF_URGENT_THRESH = 6;

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter; simultaneous up and down cancel, o_ovf flags an up lost at the ceiling.
// o_count_next exposes the value the counter takes at the next edge.
module sat_updown_counter #(
    parameter int W       = 4,
    parameter int MAX_VAL = 8
) (
    input  logic         clk_1024khz,
    input  logic         rstn,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_next,
    output logic         o_ovf
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;
    logic         w_ovf;

    always_comb begin
        w_next = r_count;
        w_ovf  = 1'b0;
        if (i_inc && !i_dec) begin
            if (r_count >= W'(MAX_VAL)) begin
                w_ovf = 1'b1;
            end else begin
                w_next = r_count + W'(1);
            end
        end else if (!i_inc && i_dec) begin
            if (r_count != '0) begin
                w_next = r_count - W'(1);
            end
        end
    end

    always_ff @(posedge clk_1024khz) begin
        if (!rstn) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_next;
    assign o_ovf        = w_ovf;

endmodule

// File: rtl/refresh_issue_tracker.sv
// Turns ref_do pulses into owed-refresh credits and issues them one by one over valid/ack.
// Define REF_TRACKER_STATS_EN to add the stat_issued / stat_peak counters.
module refresh_issue_tracker
    import ddr_ref_pkg::*;
#(
    parameter int MAX_PENDING    = DEF_MAX_PENDING,
    parameter int URGENT_THRESH  = DEF_URGENT_THRESH,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_1024khz,
    input  logic                 rstn,
    input  logic                 ref_do,
    input  logic                 ref_ack,
    output logic                 ref_valid,
    output logic                 ref_urgent,
    output logic [REF_CNT_W-1:0] pending,
    output logic                 err_overflow,
`ifdef REF_TRACKER_STATS_EN
    output logic                 err_timeout,
    output logic [15:0]          stat_issued,
    output logic [3:0]           stat_peak
`else
    output logic                 err_timeout
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    ref_trk_state_t       r_state;
    logic                 r_valid;
    logic                 r_urgent;
    logic                 r_err_ovf;
    logic                 r_err_tmo;
    logic [GAP_W-1:0]     r_gap;
    logic [TMO_W-1:0]     r_tmo;

    logic                 w_dec;
    logic                 w_ovf;
    logic [REF_CNT_W-1:0] w_pending;
    logic [REF_CNT_W-1:0] w_pending_next;

    // A credit is only consumed by an ack that meets a presented refresh.
    assign w_dec = r_valid & ref_ack;

    sat_updown_counter #(
        .W       (REF_CNT_W),
        .MAX_VAL (MAX_PENDING)
    ) u_pending (
        .clk_1024khz  (clk_1024khz),
        .rstn         (rstn),
        .i_inc        (ref_do),
        .i_dec        (w_dec),
        .o_count      (w_pending),
        .o_count_next (w_pending_next),
        .o_ovf        (w_ovf)
    );

    always_ff @(posedge clk_1024khz) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_urgent  <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_tmo <= 1'b0;
            r_gap     <= '0;
            r_tmo     <= '0;
        end else begin
            r_urgent <= (w_pending_next >= REF_CNT_W'(URGENT_THRESH));
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_pending != '0) begin
                        r_state <= REQ;
                        r_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (ref_ack) begin
                        r_tmo <= '0;
                        if (GAP_CYCLES > 0) begin
                            r_state <= GAP;
                            r_valid <= 1'b0;
                            r_gap   <= GAP_INIT;
                        end else if (w_pending_next == '0) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end
                    end else begin
                        // Stalled handshake: valid stays up, counter sticks at the limit.
                        if (r_tmo != TMO_MAX) begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                        if (r_tmo >= TMO_LAST) begin
                            r_err_tmo <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (r_gap == '0) begin
                        if (w_pending != '0) begin
                            r_state <= REQ;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef REF_TRACKER_STATS_EN
    logic [15:0] r_stat_issued;
    logic [3:0]  r_stat_peak;

    always_ff @(posedge clk_1024khz) begin
        if (!rstn) begin
            r_stat_issued <= '0;
            r_stat_peak   <= '0;
        end else begin
            if (w_dec) begin
                r_stat_issued <= r_stat_issued + 16'd1;
            end
            if (w_pending_next > r_stat_peak) begin
                r_stat_peak <= w_pending_next;
            end
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_peak   = r_stat_peak;
`endif

    assign ref_valid    = r_valid;
    assign ref_urgent   = r_urgent;
    assign pending      = w_pending;
    assign err_overflow = r_err_ovf;
    assign err_timeout  = r_err_tmo;

endmodule

// File: tb/tb_refresh_issue_tracker.sv
// Bench for refresh_issue_tracker: directed scenarios plus randomized traffic against a credit-level model.
// Stats checks are active when REF_TRACKER_STATS_EN is defined.
module tb_refresh_issue_tracker;

    localparam int MAXP = 8;
    localparam int URG  = 6;
    localparam int GAPC = 1;
    localparam int TMO  = 64;

    logic       clk_1024khz = 1'b0;
    logic       rstn        = 1'b0;
    logic       ref_do      = 1'b0;
    logic       ref_ack     = 1'b0;
    logic       ref_valid;
    logic       ref_urgent;
    logic [3:0] pending;
    logic       err_overflow;
    logic       err_timeout;
`ifdef REF_TRACKER_STATS_EN
    logic [15:0] stat_issued;
    logic [3:0]  stat_peak;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_1024khz = ~clk_1024khz;

    refresh_issue_tracker #(
        .MAX_PENDING    (MAXP),
        .URGENT_THRESH  (URG),
        .GAP_CYCLES     (GAPC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_1024khz  (clk_1024khz),
        .rstn         (rstn),
        .ref_do       (ref_do),
        .ref_ack      (ref_ack),
        .ref_valid    (ref_valid),
        .ref_urgent   (ref_urgent),
        .pending      (pending),
        .err_overflow (err_overflow),
`ifdef REF_TRACKER_STATS_EN
        .err_timeout  (err_timeout),
        .stat_issued  (stat_issued),
        .stat_peak    (stat_peak)
`else
        .err_timeout  (err_timeout)
`endif
    );

    // Credit-level view: how many refreshes are owed, whether one is on offer,
    // how many idle cycles remain after an ack, and how long the offer has waited.
    typedef struct {
        int pending;
        bit valid;
        bit urgent;
        bit ovf;
        bit tmo;
        int gap_left;
        int wait_c;
        int issued;
        int peak;
        bit live;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, bit d, bit a, bit r);
        mstate_t n;
        bit      dec;
        int      np;
        n = s;
        if (!r) begin
            n.pending = 0; n.valid = 0; n.urgent = 0; n.ovf = 0; n.tmo = 0;
            n.gap_left = 0; n.wait_c = 0; n.issued = 0; n.peak = 0; n.live = 1;
            return n;
        end
        dec = s.valid && a;
        np  = s.pending + (d ? 1 : 0) - (dec ? 1 : 0);
        if (np > MAXP) begin
            np    = MAXP;
            n.ovf = 1;
        end
        if (np < 0) np = 0;
        n.pending = np;
        n.urgent  = (np >= URG);
        if (np > s.peak) n.peak = np;
        if (dec) n.issued = (s.issued + 1) % 65536;
        if (s.valid) begin
            if (dec) begin
                n.wait_c = 0;
                if (GAPC > 0) begin
                    n.valid    = 0;
                    n.gap_left = GAPC;
                end else begin
                    n.valid = (np != 0);
                end
            end else begin
                n.wait_c = (s.wait_c < TMO) ? s.wait_c + 1 : TMO;
                if (n.wait_c >= TMO) n.tmo = 1;
            end
        end else if (s.gap_left > 1) begin
            n.gap_left = s.gap_left - 1;
        end else begin
            n.gap_left = 0;
            n.valid    = (s.pending != 0);
        end
        return n;
    endfunction

    initial begin
        m.pending = 0; m.valid = 0; m.urgent = 0; m.ovf = 0; m.tmo = 0;
        m.gap_left = 0; m.wait_c = 0; m.issued = 0; m.peak = 0; m.live = 0;
    end

    always @(posedge clk_1024khz) begin
        m <= model_next(m, ref_do, ref_ack, rstn);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_1024khz) begin
        if (m.live) begin
            chk("valid",   int'(ref_valid),    int'(m.valid));
            chk("urgent",  int'(ref_urgent),   int'(m.urgent));
            chk("pending", int'(pending),      m.pending);
            chk("err_ovf", int'(err_overflow), int'(m.ovf));
            chk("err_tmo", int'(err_timeout),  int'(m.tmo));
`ifdef REF_TRACKER_STATS_EN
            chk("stat_issued", int'(stat_issued), m.issued);
            chk("stat_peak",   int'(stat_peak),   m.peak);
`endif
        end
    end

    // Called at a falling edge; returns at the next falling edge after one rising edge.
    task automatic step(input bit d, input bit a, input bit r);
        ref_do  = d;
        ref_ack = a;
        rstn    = r;
        @(negedge clk_1024khz);
    endtask

    task automatic do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    initial begin
        int p_do;
        int p_ack;
        int pct [5];
        pct = '{0, 10, 50, 90, 100};

        @(negedge clk_1024khz);
        do_reset();
        chk("rst_valid",   int'(ref_valid), 0);
        chk("rst_pending", int'(pending),   0);

        // Single pulse with ack held high.
        step(1, 1, 1);
        chk("sp_pend1",  int'(pending),   1);
        chk("sp_valid0", int'(ref_valid), 0);
        step(0, 1, 1);
        chk("sp_valid1", int'(ref_valid), 1);
        chk("mdl_sp_valid1", int'(m.valid), 1);
        step(0, 1, 1);
        chk("sp_pend0",  int'(pending),   0);
        chk("sp_gap",    int'(ref_valid), 0);
        step(0, 1, 1);
        chk("sp_idle",   int'(ref_valid), 0);

        // Burst overflow with no acks.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(1, 0, 1);
            chk("bo_pending", int'(pending),      (k < MAXP) ? k : MAXP);
            chk("bo_urgent",  int'(ref_urgent),   (k >= URG) ? 1 : 0);
            chk("bo_ovf",     int'(err_overflow), (k > MAXP) ? 1 : 0);
        end
        chk("mdl_bo_pending", m.pending, 8);

        // Simultaneous inc/dec.
        do_reset();
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 1);
        chk("id_pend3", int'(pending),   3);
        chk("id_valid", int'(ref_valid), 1);
        step(1, 1, 1);
        chk("id_hold3", int'(pending),   3);
        chk("id_gap",   int'(ref_valid), 0);
        step(0, 0, 1);
        chk("id_back",  int'(ref_valid), 1);

        // Timeout.
        do_reset();
        step(1, 0, 1);
        step(0, 0, 1);
        chk("to_valid", int'(ref_valid), 1);
        for (int k = 0; k < TMO - 1; k++) step(0, 0, 1);
        chk("to_before", int'(err_timeout), 0);
        step(0, 0, 1);
        chk("to_set",    int'(err_timeout), 1);
        chk("to_vstay",  int'(ref_valid),   1);
        chk("mdl_to_set", int'(m.tmo), 1);
        step(0, 1, 1);
        chk("to_pend0",  int'(pending),     0);
        chk("to_sticky", int'(err_timeout), 1);

        // Reset in the middle of a handshake.
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 0, 1);
        chk("rq_pend5", int'(pending),   5);
        chk("rq_valid", int'(ref_valid), 1);
        step(0, 0, 0);
        chk("rq_pend0",  int'(pending),    0);
        chk("rq_valid0", int'(ref_valid),  0);
        chk("rq_urg0",   int'(ref_urgent), 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1);
            chk("rq_nostray", int'(ref_valid), 0);
        end

`ifdef REF_TRACKER_STATS_EN
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 0, 1);
        for (int k = 0; k < 10; k++) step(0, 1, 1);
        chk("st_issued", int'(stat_issued), 5);
        chk("st_peak",   int'(stat_peak),   5);
`endif

        // Randomized traffic in segments of varying density.
        do_reset();
        for (int seg = 0; seg < 24; seg++) begin
            p_do  = pct[$urandom_range(4)];
            p_ack = pct[$urandom_range(4)];
            for (int c = 0; c < 150; c++) begin
                step($urandom_range(99) < p_do, $urandom_range(99) < p_ack,
                     $urandom_range(299) != 0);
            end
        end

        step(0, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/refresh_issue_tracker.md
Name: refresh_issue_tracker

Overview:
- Sits directly downstream of the refresh controller, on the command-generator side.
- Converts each `ref_do` assertion into one owed-refresh credit, queues up to MAX_PENDING credits, and presents them one at a time to the command generator over a valid/ack handshake.
- Flags urgency, dropped credits (overflow) and stalled handshakes (timeout).

Parameters:
- MAX_PENDING, 8: credit saturation limit (DDR postpone limit); must be 1..15.
- URGENT_THRESH, 6: `ref_urgent` asserts when pending >= this value; must be <= MAX_PENDING.
- GAP_CYCLES, 1: idle cycles enforced after each acknowledged refresh; 0 allowed.
- TIMEOUT_CYCLES, 64: cycles `ref_valid` may stay unacknowledged before `err_timeout` sets.

Ports:
- clk_1024khz  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- ref_do  in  1  from refresh controller; each sampled-high cycle = one owed refresh.
- ref_ack  in  1  command generator accepts the presented refresh; synchronous to clk_1024khz.
- ref_valid  out  1  a refresh is presented.
- ref_urgent  out  1  backlog at or above URGENT_THRESH.
- pending  out  4  credits owed, including the one presented.
- err_overflow  out  1  sticky; a credit was dropped.
- err_timeout  out  1  sticky; handshake stalled.

Behaviour:
- Reset (`rstn` low at a clock edge) forces all of the following to 0 the next cycle, mid-handshake included:
  - outputs `ref_valid`, `ref_urgent`, `pending`, `err_overflow`, `err_timeout`;
  - state IDLE, gap counter and timeout counter.
- All outputs are registered.
- Credit arithmetic:
  - inc = `ref_do`; dec = `ref_valid` && `ref_ack`.
  - inc only: `pending`+1.
  - dec only: `pending`-1.
  - Both: `pending` unchanged.
  - inc with `pending` == MAX_PENDING and no dec: credit dropped, `pending` held, `err_overflow` set.
  - `pending` never wraps or underflows.
- `ref_ack` while `ref_valid` is low is ignored and causes no decrement.
- FSM states IDLE, REQ, GAP:
  - IDLE: `pending` != 0 -> REQ.
  - REQ: `ref_valid`=1. If `ref_ack`: GAP_CYCLES>0 -> GAP, load gap counter; else `pending` after update != 0 -> stay REQ, else IDLE.
  - GAP: `ref_valid`=0; count down. At 0: `pending` != 0 -> REQ, else IDLE.
- Handshake rules:
  - `ref_valid`, once high, stays high until the ack cycle; it is never withdrawn.
  - Exactly one credit is consumed per ack cycle.
- Latency:
  - `ref_do` high at edge N -> `pending`=1 after N -> `ref_valid` high after edge N+1 (from IDLE).
  - Ack at edge M with GAP_CYCLES=1 -> `ref_valid` low for exactly 1 cycle, re-high after M+2 if credits remain.
- `ref_urgent` = registered (`pending`_next >= URGENT_THRESH); it tracks the same edge as `pending`.
- Timeout:
  - Counter runs only in REQ; cleared on ack or on leaving REQ.
  - Reaching TIMEOUT_CYCLES sets `err_timeout`; `ref_valid` stays asserted and the counter saturates.
- Error flags clear only on reset.

Optional Feature:
- Macro: REF_TRACKER_STATS_EN.
- Defined:
  - Adds outputs `stat_issued` (16 bit) and `stat_peak` (4 bit).
  - `stat_issued`: wrapping count of ack handshakes.
  - `stat_peak`: highest `pending` value since reset.
  - Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package `ddr_ref_pkg`:
  - enum `ref_trk_state_t` {IDLE, REQ, GAP};
  - localparam `REF_CNT_W`=4;
  - default constants for MAX_PENDING and URGENT_THRESH, shared with the refresh controller's postpone limit.
- One sub-module, `sat_updown_counter`: saturating up/down counter with overflow pulse, used for `pending`.
- FSM, gap counter and timeout counter stay in the top module.

Test Plan:
- Single pulse: `ref_do` 1 cycle at edge 10, `ref_ack` held high -> `ref_valid` high after edge 11, `pending` 1->0 at the ack edge, `ref_valid` low for 1 gap cycle then IDLE.
- Burst overflow: `ref_do` high 10 cycles, no ack -> `pending` saturates at 8, `ref_urgent` set when `pending`=6, `err_overflow`=1 after the 9th cycle.
- Simultaneous inc/dec: `pending`=3, `ref_do` and ack in the same cycle -> `pending` stays 3; `ref_valid` drops for the gap then returns.
- Timeout: `pending`=1, no ack for 64 cycles -> `err_timeout`=1 at cycle 64; `ref_valid` still 1; a later ack leaves `pending`=0 and the error stays set.
- Reset mid-REQ: `pending`=5, `ref_valid` high, `rstn` low one edge -> all outputs 0 next cycle; no stray valid afterwards.
- Stats (macro defined): 5 credits, 5 acks -> `stat_issued`=5, `stat_peak`=5.
